imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single read port of the instruction ROM between two requesters: the CPU instruction-fetch (IF) stage and a debug/boot reader (DBG).
- Grants one requester per cycle, drives the ROM enable and address, and registers the ROM word.
- Returns the word to the winner one cycle later, tagged with rvalid.
- Raises a stall request to the pipeline controller whenever IF is blocked.
- Sits between the pc/IF stage, the debug unit and the instruction ROM.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus).
- DATA_W, 32, instruction word width (matches InstBus).
- MAX_DBG_WAIT, 4, consecutive cycles DBG may be refused under fixed priority before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF requests a read.
- if_addr  in  ADDR_W  IF byte address.
- if_gnt  out  1  IF wins this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_W  word for the last granted IF request.
- dbg_req  in  1  DBG requests a read.
- dbg_addr  in  ADDR_W  DBG byte address.
- dbg_gnt  out  1  DBG wins this cycle.
- dbg_rvalid  out  1  dbg_rdata valid.
- dbg_rdata  out  DATA_W  word for the last granted DBG request.
- rom_ce  out  1  ROM chip enable (ChipEnable when a grant is issued).
- rom_addr  out  ADDR_W  address to the ROM.
- rom_inst  in  DATA_W  ROM read data, combinational from rom_addr.
- stallreq  out  1  to the pipeline controller: IF is blocked.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset outputs:
  - rvalid and rdata outputs are 0.
  - Internal state is IDLE, last_gnt = IF, wait_cnt = 0.
  - While rst is high, if_gnt, dbg_gnt, rom_ce and stallreq are 0 and rom_addr is 0, regardless of the inputs.
- Grant logic (combinational from current inputs and state):
  - At most one of if_gnt and dbg_gnt is high.
  - A requester is granted only while its req is high.
- Requester rule: a requester holds req and addr stable until it sees gnt. It may drop req in the cycle after gnt, or keep req high to issue back-to-back reads.
- ROM side:
  - rom_ce = if_gnt | dbg_gnt.
  - rom_addr = the granted requester's address, otherwise 0.
- Read latency is exactly 1 cycle:
  - On the clk edge that ends a grant cycle, rom_inst is captured into the winner's rdata register and its rvalid is set for exactly one cycle.
  - The other requester's rdata holds its previous value and its rvalid is 0.
- Throughput: one grant per cycle; full back-to-back streaming is allowed.
- FSM states (record the previous cycle's owner):
  - IDLE: no grant last cycle.
  - IF_XFER: IF was granted.
  - DBG_XFER: DBG was granted.
  - Transitions to IF_XFER, DBG_XFER or IDLE according to this cycle's grant.
- Fixed-priority arbitration (default build):
  - If only one requester is asserting req, it wins.
  - If both are asserting req, IF wins, unless wait_cnt == MAX_DBG_WAIT, in which case DBG wins.
- wait_cnt:
  - Increments each cycle that dbg_req=1 and dbg_gnt=0, saturating at MAX_DBG_WAIT.
  - Clears on a DBG grant, or on any cycle with dbg_req=0.
- stallreq = if_req & ~if_gnt.
- Reset mid-transfer: any pending rvalid is dropped (it is not asserted after rst deasserts). The FSM returns to IDLE and wait_cnt to 0.
- Address passthrough: addresses go to the ROM unmodified; word indexing stays in the ROM.
- last_gnt is updated on every grant.

Optional Feature:
- Macro: IMEM_ARB_RR_EN.
- When defined:
  - Contention is resolved round-robin: the requester not in last_gnt wins.
  - wait_cnt and MAX_DBG_WAIT are unused; wait_cnt is held at 0.
  - Worst-case wait for either requester is 1 cycle.
- When undefined: fixed priority with the starvation counter, as described under Behaviour.

Test Plan:
- Reset while both reqs are high:
  - Stimulus: rst=1 with if_req=dbg_req=1.
  - Required: all grants, rom_ce, rvalid and stallreq are 0. After rst=0, IF is granted first (if_gnt=1, rom_addr=if_addr).
- IF-only stream:
  - Stimulus: if_addr 0x0, 0x4, 0x8 on consecutive cycles, with ROM words 0x34011100, 0x34020020, 0x3403ff00.
  - Required: if_rvalid is high for 3 consecutive cycles starting 1 cycle after the first grant, with matching data, and stallreq=0 throughout.
- Contention, fixed priority, MAX_DBG_WAIT=4:
  - Stimulus: if_req and dbg_req held high continuously.
  - Required: IF is granted 4 cycles, then DBG 1 cycle (stallreq=1 in that cycle), and the pattern repeats.
- DBG released mid-wait:
  - Stimulus: dbg_req high for 2 contended cycles, then low for 1 cycle, then high again.
  - Required: wait_cnt restarts from 0, so DBG wins only after 4 further contended cycles.
- IMEM_ARB_RR_EN defined, both requesting:
  - Required: grants alternate IF, DBG, IF, DBG, and each rvalid/rdata pairs with its own address (0x10 for IF, 0x200 for DBG).
- Reset asserted mid-transfer:
  - Stimulus: rst asserted in the cycle right after a DBG grant.
  - Required: dbg_rvalid is never asserted for that grant, and dbg_rdata reads 0.

Source files
------------

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-requester instruction ROM read-port arbiter with one-cycle registered return
// Optional: IMEM_ARB_RR_EN selects round-robin contention instead of fixed priority with a starvation counter.
module imem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DBG_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_XFER  = 2'd1,
        DBG_XFER = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_DBG_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic       dbg_wins;

`ifdef IMEM_ARB_RR_EN
    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_DBG = 1'b1;
    logic last_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= GNT_IF;
        end else if (if_gnt) begin
            last_gnt <= GNT_IF;
        end else if (dbg_gnt) begin
            last_gnt <= GNT_DBG;
        end
    end
`endif

    always_comb begin
        if_gnt    = 1'b0;
        dbg_gnt   = 1'b0;
        state_nxt = IDLE;
        wait_nxt  = 4'd0;
`ifdef IMEM_ARB_RR_EN
        dbg_wins  = (last_gnt == GNT_IF);
`else
        dbg_wins  = (wait_cnt == WAIT_MAX);
`endif
        if (!rst) begin
            if (if_req && dbg_req) begin
                dbg_gnt = dbg_wins;
                if_gnt  = ~dbg_wins;
            end else begin
                if_gnt  = if_req;
                dbg_gnt = dbg_req;
            end
        end
        if (if_gnt) begin
            state_nxt = IF_XFER;
        end else if (dbg_gnt) begin
            state_nxt = DBG_XFER;
        end
`ifndef IMEM_ARB_RR_EN
        // Counts refused DBG cycles; any gap in dbg_req restarts the count.
        if (dbg_req && !dbg_gnt) begin
            wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata  <= '0;
            dbg_rdata <= '0;
        end else begin
            if (if_gnt) begin
                if_rdata <= rom_inst;
            end
            if (dbg_gnt) begin
                dbg_rdata <= rom_inst;
            end
        end
    end

    // The state records last cycle's winner, which is exactly who gets data now.
    assign if_rvalid  = (state == IF_XFER);
    assign dbg_rvalid = (state == DBG_XFER);

    assign rom_ce   = if_gnt | dbg_gnt;
    assign rom_addr = if_gnt ? if_addr : (dbg_gnt ? dbg_addr : '0);
    assign stallreq = if_req & ~if_gnt & ~rst;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed vector bench for imem_arbiter (fixed-priority build)
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stallreq;

    int errors = 0;
    int checks = 0;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DBG_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        case (a)
            32'h0:   rom_model = 32'h3401_1100;
            32'h4:   rom_model = 32'h3402_0020;
            32'h8:   rom_model = 32'h3403_ff00;
            32'h10:  rom_model = 32'h1111_0010;
            32'h200: rom_model = 32'h2222_0200;
            default: rom_model = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign rom_inst = rom_model(rom_addr);

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        eig;
        logic        edg;
        logic [31:0] ea;
        logic        est;
        logic        eirv;
        logic [31:0] eird;
        logic        edrv;
        logic [31:0] edrd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic [31:0] da,
                                input logic eig, input logic edg, input logic [31:0] ea,
                                input logic est, input logic eirv, input logic [31:0] eird,
                                input logic edrv, input logic [31:0] edrd);
        vec_t v;
        v = '{r, ir, ia, dr, da, eig, edg, ea, est, eirv, eird, edrv, edrd};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, required %h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] W0  = 32'h3401_1100;
    localparam logic [31:0] W4  = 32'h3402_0020;
    localparam logic [31:0] W8  = 32'h3403_ff00;
    localparam logic [31:0] WI  = 32'h1111_0010;
    localparam logic [31:0] WD  = 32'h2222_0200;
    localparam logic [31:0] W40 = 32'hC0DE_0040;

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; dbg_req = 1'b1; dbg_addr = 32'h200;

        //  rst ir ia     dr da      |  ig dg addr    st irv ird  drv drd
        add(1, 1, 32'h10, 1, 32'h200,   0, 0, 32'h0,   0, 0, 0,   0, 0);
        // contention: IF x4, DBG x1, repeating
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 0, 0,   0, 0);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, 0);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, 0);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, 0);
        add(0, 1, 32'h10, 1, 32'h200,   0, 1, 32'h200, 1, 1, WI,  0, 0);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 0, WI,  1, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   0, 1, 32'h200, 1, 1, WI,  0, WD);
        // IF-only stream
        add(0, 1, 32'h0,  0, 32'h200,   1, 0, 32'h0,   0, 0, WI,  1, WD);
        add(0, 1, 32'h4,  0, 32'h200,   1, 0, 32'h4,   0, 1, W0,  0, WD);
        add(0, 1, 32'h8,  0, 32'h200,   1, 0, 32'h8,   0, 1, W4,  0, WD);
        add(0, 0, 32'h8,  0, 32'h200,   0, 0, 32'h0,   0, 1, W8,  0, WD);
        add(0, 0, 32'h8,  0, 32'h200,   0, 0, 32'h0,   0, 0, W8,  0, WD);
        // DBG released mid-wait: count restarts
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 0, W8,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 0, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   1, 0, 32'h10,  0, 1, WI,  0, WD);
        add(0, 1, 32'h10, 1, 32'h200,   0, 1, 32'h200, 1, 1, WI,  0, WD);
        // DBG alone, new address
        add(0, 0, 32'h10, 1, 32'h40,    0, 1, 32'h40,  0, 0, WI,  1, WD);
        add(0, 0, 32'h10, 0, 32'h40,    0, 0, 32'h0,   0, 0, WI,  1, W40);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            rst = vecs[i].rst; if_req = vecs[i].ir; if_addr = vecs[i].ia;
            dbg_req = vecs[i].dr; dbg_addr = vecs[i].da;
            @(negedge clk);
            check("if_gnt",     i, 32'(if_gnt),     32'(vecs[i].eig));
            check("dbg_gnt",    i, 32'(dbg_gnt),    32'(vecs[i].edg));
            check("rom_ce",     i, 32'(rom_ce),     32'(vecs[i].eig | vecs[i].edg));
            check("rom_addr",   i, rom_addr,        vecs[i].ea);
            check("stallreq",   i, 32'(stallreq),   32'(vecs[i].est));
            check("if_rvalid",  i, 32'(if_rvalid),  32'(vecs[i].eirv));
            check("if_rdata",   i, if_rdata,        vecs[i].eird);
            check("dbg_rvalid", i, 32'(dbg_rvalid), 32'(vecs[i].edrv));
            check("dbg_rdata",  i, dbg_rdata,       vecs[i].edrd);
        end

        // Reset lands right after a DBG grant: the return must be dropped.
        @(posedge clk); #1;
        if_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h200;
        @(negedge clk);
        check("mid_dbg_gnt", 100, 32'(dbg_gnt), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        check("mid_dbg_rvalid", 101, 32'(dbg_rvalid), 32'd0);
        check("mid_dbg_rdata",  101, dbg_rdata,       32'd0);
        check("mid_if_rdata",   101, if_rdata,        32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_dbg_rvalid", 102, 32'(dbg_rvalid), 32'd0);
        check("post_rom_ce",     102, 32'(rom_ce),     32'd0);
        // Counter restarted by reset: both requesting again gives IF first.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10; dbg_req = 1'b1;
        @(negedge clk);
        check("post_if_gnt", 103, 32'(if_gnt), 32'd1);
        check("post_stall",  103, 32'(stallreq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
